// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with valid/ready load and frame marker
// Output bits are registered so the far-side capture flop sees a full clk period of setup.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_bit;

  assign last_bit  = (cnt == '0);
  assign din_ready = (state == IDLE) || ((state == SHIFT) && last_bit);
  assign accept    = din_valid && din_ready;
  assign busy      = (state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_bit && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The first bit goes straight to sout on load; sreg holds only the bits still to send.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg        <= '0;
      cnt         <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else if (accept) begin
      if (MSB_FIRST) begin
        sout <= din[WIDTH-1];
        sreg <= din << 1;
      end else begin
        sout <= din[0];
        sreg <= din >> 1;
      end
      cnt         <= CNT_MAX;
      sout_valid  <= 1'b1;
      frame_start <= 1'b1;
    end else if ((state == SHIFT) && !last_bit) begin
      if (MSB_FIRST) begin
        sout <= sreg[WIDTH-1];
        sreg <= sreg << 1;
      end else begin
        sout <= sreg[0];
        sreg <= sreg >> 1;
      end
      cnt         <= cnt - 1'b1;
      frame_start <= 1'b0;
    end else begin
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer (MSB-first and LSB-first instances)
module tb_piso_serializer;

  typedef struct packed {
    logic b;
    logic fs;
    logic contig;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din0 = '0, din1 = '0;
  logic       din0_valid = 1'b0, din1_valid = 1'b0;
  logic       din0_ready, din1_ready;
  logic       sout0, sout1, sout0_valid, sout1_valid;
  logic       fs0, fs1, busy0, busy1;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc0 = 0, cyc1 = 0, last0 = -10, last1 = -10;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din0), .din_valid(din0_valid), .din_ready(din0_ready),
    .sout(sout0), .sout_valid(sout0_valid), .frame_start(fs0), .busy(busy0)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(din1_valid), .din_ready(din1_ready),
    .sout(sout1), .sout_valid(sout1_valid), .frame_start(fs1), .busy(busy1)
  );

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      cyc0++;
      check("m0_busy", busy0, sout0_valid);
      if (sout0_valid) begin
        if (q0.size() == 0) begin
          check("m0_unexpected_bit", 1, 0);
        end else begin
          e = q0.pop_front();
          check("m0_sout", sout0, e.b);
          check("m0_frame_start", fs0, e.fs);
          if (e.contig) check("m0_gap", last0, cyc0 - 1);
        end
        last0 = cyc0;
      end else begin
        check("m0_idle_sout", sout0, 0);
        check("m0_idle_fs", fs0, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      cyc1++;
      check("m1_busy", busy1, sout1_valid);
      if (sout1_valid) begin
        if (q1.size() == 0) begin
          check("m1_unexpected_bit", 1, 0);
        end else begin
          e = q1.pop_front();
          check("m1_sout", sout1, e.b);
          check("m1_frame_start", fs1, e.fs);
          if (e.contig) check("m1_gap", last1, cyc1 - 1);
        end
        last1 = cyc1;
      end else begin
        check("m1_idle_sout", sout1, 0);
        check("m1_idle_fs", fs1, 0);
      end
    end
  end

  // Called at a negedge; exp_bits lists the serial sequence with the first bit in [7].
  task automatic send(input int idx, input logic [7:0] w, input logic [7:0] exp_bits,
                      input bit contig_first, input bit keep_valid, output int waits);
    exp_t e;
    waits = 0;
    if (idx == 0) begin din0 = w; din0_valid = 1'b1; end
    else          begin din1 = w; din1_valid = 1'b1; end
    while (((idx == 0) ? din0_ready : din1_ready) !== 1'b1 && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 200) check("ready_timeout", waits, 0);
    for (int i = 0; i < 8; i++) begin
      e.b      = exp_bits[7-i];
      e.fs     = (i == 0);
      e.contig = (i == 0) ? contig_first : 1'b1;
      if (idx == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
    @(negedge clk);
    if (!keep_valid) begin
      if (idx == 0) begin din0_valid = 1'b0; din0 = ~w; end
      else          begin din1_valid = 1'b0; din1 = ~w; end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int w;
    @(negedge clk);
    check("rst_sout", sout0, 0);
    check("rst_sout_valid", sout0_valid, 0);
    check("rst_frame_start", fs0, 0);
    check("rst_busy", busy0, 0);
    check("rst_din_ready", din0_ready, 1);
    check("rst_din_ready_lsb", din1_ready, 1);
    rst_n = 1'b1;
    idle_cycles(2);

    send(0, 8'hA5, 8'b1010_0101, 1'b0, 1'b0, w);
    check("t2_accept_wait", w, 0);
    idle_cycles(10);

    send(1, 8'h01, 8'b1000_0000, 1'b0, 1'b0, w);
    idle_cycles(10);

    send(0, 8'hFF, 8'hFF, 1'b0, 1'b1, w);
    check("t4_ready_midword", din0_ready, 0);
    send(0, 8'h00, 8'h00, 1'b1, 1'b0, w);
    check("t4_hold_cycles", w, 7);
    idle_cycles(10);

    send(0, 8'h96, 8'b1001_0110, 1'b0, 1'b1, w);
    check("t5_ready_midword", din0_ready, 0);
    check("t5_busy_midword", busy0, 1);
    send(0, 8'h5A, 8'b0101_1010, 1'b1, 1'b0, w);
    check("t5_hold_cycles", w, 7);
    send(1, 8'hC8, 8'b0001_0011, 1'b0, 1'b1, w);
    send(1, 8'h81, 8'b1000_0001, 1'b1, 1'b0, w);
    check("t5_hold_cycles_lsb", w, 7);
    idle_cycles(10);

    send(0, 8'hC3, 8'b1100_0011, 1'b0, 1'b0, w);
    idle_cycles(2);
    #2 rst_n = 1'b0;
    #1;
    check("abort_sout", sout0, 0);
    check("abort_sout_valid", sout0_valid, 0);
    check("abort_frame_start", fs0, 0);
    check("abort_busy", busy0, 0);
    check("abort_din_ready", din0_ready, 1);
    check("abort_bits_remaining", q0.size(), 5);
    q0.delete();
    #1 rst_n = 1'b1;
    idle_cycles(3);
    send(0, 8'h3C, 8'b0011_1100, 1'b0, 1'b0, w);
    idle_cycles(12);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
